exe_ctrl_sequencer: RTL and testbench

Consumer end of the EXE->CTRL payload (`exe2ctrl_t`). The block owns the architectural fetch PC and decodes `pc_ctrl` into next-PC redirects. It detects load-use and CSR read-after-write hazards and drives stall, flush and bubble controls to the IF/ID/EXE pipeline registers. It sits in the Pipeline Controller, between EXE, ID and the fetch unit.

---
 rtl/core_pkg.sv | 48 ++++
 rtl/next_pc_decode.sv | 36 +++
 rtl/exe_ctrl_sequencer.sv | 110 +++++++++++
 tb/tb_exe_ctrl_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the EXE->CTRL interface and the pipeline
// controller sequencer.
package core_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int RF_ADDR_WIDTH  = 5;
  localparam int CSR_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    PC_INC  = 2'd0,
    PC_SET  = 2'd1,
    PC_ADD  = 2'd2,
    PC_COND = 2'd3
  } pc_ctrl_t;

  typedef enum logic [1:0] {
    CSR_IDLE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_ctrl_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     pc;
    logic [RF_ADDR_WIDTH-1:0]  rd;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
    logic [DATA_WIDTH-1:0]     exe_out;
    logic [DATA_WIDTH-1:0]     op3;
    pc_ctrl_t                  pc_ctrl;
    csr_ctrl_t                 csr_ctrl;
  } exe2ctrl_t;

  // Sequencer states kept as plain constants so legacy netlists can match
  // the encodings directly.
  typedef logic [1:0] exe_ctrl_state_t;
  localparam exe_ctrl_state_t RESET    = 2'd0;
  localparam exe_ctrl_state_t RUN      = 2'd1;
  localparam exe_ctrl_state_t CSR_WAIT = 2'd2;

  function automatic logic [ADDR_WIDTH-1:0] pc_add(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [ADDR_WIDTH-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/next_pc_decode.sv
// Combinational decode of an EXE pc_ctrl field into a redirect request and
// its target address.
module next_pc_decode
  import core_pkg::*;
(
  input  logic                  i_valid,
  input  logic [1:0]            i_pc_ctrl,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_exe_out,
  input  logic [DATA_WIDTH-1:0] i_op3,
  output logic                  o_redirect,
  output logic [ADDR_WIDTH-1:0] o_target
);

  logic [ADDR_WIDTH-1:0] w_rel_target;

  // op3 is truncated to the address width; the sum wraps naturally.
  assign w_rel_target = pc_add(i_pc, i_op3[ADDR_WIDTH-1:0]);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    o_redirect = 1'b0;
    o_target   = w_rel_target;
    case (i_pc_ctrl)
      PC_SET: begin
        o_redirect = i_valid;
        o_target   = {i_exe_out[ADDR_WIDTH-1:1], 1'b0};
      end
      PC_ADD:  o_redirect = i_valid;
      PC_COND: o_redirect = i_valid & i_exe_out[0];
      default: o_redirect = 1'b0;
    endcase
  end

endmodule

// File: rtl/exe_ctrl_sequencer.sv
// Pipeline controller sequencer: owns the fetch PC, applies EXE redirects and
// resolves load-use / CSR read-after-write hazards with stall and bubble.
module exe_ctrl_sequencer
  import core_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  exe2ctrl_t                exe2ctrl_i,
  input  logic                     exe_valid_i,
  input  logic                     exe_is_load_i,
  input  logic                     id_valid_i,
  input  logic [RF_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [RF_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic [1:0]               id_rs_use_i,
  input  logic                     id_csr_use_i,
  input  logic                     wb_csr_done_i,
  input  logic                     fetch_ready_i,
  output logic [ADDR_WIDTH-1:0]    pc_o,
  output logic                     pc_valid_o,
  output logic                     stall_o,
  output logic                     bubble_o,
  output logic                     flush_o
);

  exe_ctrl_state_t       r_state;
  exe_ctrl_state_t       w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_pc_valid;

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_active;
  logic                  w_redirect_taken;
  logic                  w_load_use;
  logic                  w_csr_hazard;
  logic                  w_stall;
  logic                  w_advance;
  logic                  w_unused_payload;

  // The controller does not need the CSR address or the EXE pc beyond decode.
  assign w_unused_payload = ^exe2ctrl_i.csr_waddr;

  next_pc_decode u_next_pc_decode (
    .i_valid    (exe_valid_i),
    .i_pc_ctrl  (exe2ctrl_i.pc_ctrl),
    .i_pc       (exe2ctrl_i.pc),
    .i_exe_out  (exe2ctrl_i.exe_out),
    .i_op3      (exe2ctrl_i.op3),
    .o_redirect (w_redirect),
    .o_target   (w_target)
  );

  // Nothing acts while reset is asserted or during the post-reset cycle.
  assign w_active         = !rst_i && (r_state != RESET);
  assign w_redirect_taken = w_active && w_redirect;

  assign w_load_use = exe_valid_i && exe_is_load_i && id_valid_i &&
                      (exe2ctrl_i.rd != '0) &&
                      ((id_rs_use_i[0] && (id_rs1_i == exe2ctrl_i.rd)) ||
                       (id_rs_use_i[1] && (id_rs2_i == exe2ctrl_i.rd)));

  assign w_csr_hazard = exe_valid_i && (exe2ctrl_i.csr_ctrl != CSR_IDLE) &&
                        id_valid_i && id_csr_use_i;

  assign w_stall = w_active && !w_redirect &&
                   ((r_state == CSR_WAIT) || w_csr_hazard || w_load_use);

  assign w_advance = r_pc_valid && fetch_ready_i && !w_stall;

  always_comb begin
    w_state_next = RUN;
    if (r_state == RESET) begin
      w_state_next = RUN;
    end else if (w_redirect) begin
      w_state_next = RUN;
    end else if (r_state == CSR_WAIT) begin
      w_state_next = wb_csr_done_i ? RUN : CSR_WAIT;
    end else if (w_csr_hazard) begin
      w_state_next = CSR_WAIT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RESET;
      r_pc       <= RESET_ADDR;
      r_pc_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == RESET) begin
        r_pc_valid <= 1'b1;
      end else if (w_redirect_taken) begin
        r_pc <= w_target;
      end else if (w_advance) begin
        r_pc <= pc_add(r_pc, ADDR_WIDTH'(4));
      end
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = r_pc_valid;
  assign stall_o    = w_stall;
  assign bubble_o   = w_stall;
  assign flush_o    = w_redirect_taken;

endmodule

// File: tb/tb_exe_ctrl_sequencer.sv
// Directed scoreboard bench for exe_ctrl_sequencer: expected outputs are
// queued per cycle and compared against the DUT away from the clock edge.
module tb_exe_ctrl_sequencer;
  import core_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] RST_PC = 32'h100;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  exe2ctrl_t                exe2ctrl_i;
  logic                     exe_valid_i;
  logic                     exe_is_load_i;
  logic                     id_valid_i;
  logic [RF_ADDR_WIDTH-1:0] id_rs1_i;
  logic [RF_ADDR_WIDTH-1:0] id_rs2_i;
  logic [1:0]               id_rs_use_i;
  logic                     id_csr_use_i;
  logic                     wb_csr_done_i;
  logic                     fetch_ready_i;
  logic [ADDR_WIDTH-1:0]    pc_o;
  logic                     pc_valid_o;
  logic                     stall_o;
  logic                     bubble_o;
  logic                     flush_o;

  exe_ctrl_sequencer #(.RESET_ADDR(RST_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .exe2ctrl_i    (exe2ctrl_i),
    .exe_valid_i   (exe_valid_i),
    .exe_is_load_i (exe_is_load_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs_use_i   (id_rs_use_i),
    .id_csr_use_i  (id_csr_use_i),
    .wb_csr_done_i (wb_csr_done_i),
    .fetch_ready_i (fetch_ready_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .stall_o       (stall_o),
    .bubble_o      (bubble_o),
    .flush_o       (flush_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        pc_valid;
    logic        stall;
    logic        bubble;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
    end
  endtask

  // Queue the expectation for this cycle, sample 1ns later, then move on to
  // the next falling edge where new stimulus is applied.
  task automatic cyc(input string tag, input logic [31:0] pc,
                     input logic v, input logic s, input logic f);
    exp_t e;
    e.tag = tag; e.pc = pc; e.pc_valid = v; e.stall = s; e.bubble = s; e.flush = f;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    cmp(e.tag, "pc",       pc_o,               e.pc);
    cmp(e.tag, "pc_valid", {31'b0, pc_valid_o}, {31'b0, e.pc_valid});
    cmp(e.tag, "stall",    {31'b0, stall_o},    {31'b0, e.stall});
    cmp(e.tag, "bubble",   {31'b0, bubble_o},   {31'b0, e.bubble});
    cmp(e.tag, "flush",    {31'b0, flush_o},    {31'b0, e.flush});
    @(negedge clk_i);
  endtask

  task automatic set_exe(input logic valid, input pc_ctrl_t ctrl,
                         input csr_ctrl_t csr, input logic [31:0] pc,
                         input logic [31:0] op3, input logic [31:0] out,
                         input logic [4:0] rd, input logic load);
    exe_valid_i         = valid;
    exe_is_load_i       = load;
    exe2ctrl_i.pc       = pc;
    exe2ctrl_i.rd       = rd;
    exe2ctrl_i.csr_waddr = 12'h300;
    exe2ctrl_i.exe_out  = out;
    exe2ctrl_i.op3      = op3;
    exe2ctrl_i.pc_ctrl  = ctrl;
    exe2ctrl_i.csr_ctrl = csr;
  endtask

  task automatic clear_all();
    set_exe(1'b0, PC_INC, CSR_IDLE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    id_valid_i    = 1'b0;
    id_rs1_i      = '0;
    id_rs2_i      = '0;
    id_rs_use_i   = 2'b00;
    id_csr_use_i  = 1'b0;
    wb_csr_done_i = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    fetch_ready_i = 1'b0;
    clear_all();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);

    // Reset state and release
    cyc("reset", RST_PC, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0; fetch_ready_i = 1'b1;
    cyc("post_reset", RST_PC, 1'b0, 1'b0, 1'b0);
    cyc("seq0", 32'h100, 1'b1, 1'b0, 1'b0);
    cyc("seq1", 32'h104, 1'b1, 1'b0, 1'b0);
    cyc("seq2", 32'h108, 1'b1, 1'b0, 1'b0);

    // PC_COND taken with negative offset
    set_exe(1'b1, PC_COND, CSR_IDLE, 32'h200, 32'hFFFF_FFF0, 32'h1, 5'd0, 1'b0);
    cyc("cond_taken", 32'h10C, 1'b1, 1'b0, 1'b1);
    clear_all();
    cyc("cond_target", 32'h1F0, 1'b1, 1'b0, 1'b0);

    // PC_COND not taken
    set_exe(1'b1, PC_COND, CSR_IDLE, 32'h200, 32'hFFFF_FFF0, 32'h0, 5'd0, 1'b0);
    cyc("cond_not_taken", 32'h1F4, 1'b1, 1'b0, 1'b0);
    clear_all();
    cyc("cond_seq", 32'h1F8, 1'b1, 1'b0, 1'b0);

    // PC_SET while fetch is not ready
    set_exe(1'b1, PC_SET, CSR_IDLE, 32'h400, 32'h0, 32'h3001, 5'd1, 1'b0);
    fetch_ready_i = 1'b0;
    cyc("jalr", 32'h1FC, 1'b1, 1'b0, 1'b1);
    clear_all();
    cyc("jalr_target", 32'h3000, 1'b1, 1'b0, 1'b0);
    cyc("jalr_hold", 32'h3000, 1'b1, 1'b0, 1'b0);
    fetch_ready_i = 1'b1;
    cyc("jalr_ready", 32'h3000, 1'b1, 1'b0, 1'b0);
    cyc("jalr_adv", 32'h3004, 1'b1, 1'b0, 1'b0);

    // PC_ADD (JAL) with wrap-around
    set_exe(1'b1, PC_ADD, CSR_IDLE, 32'hFFFF_FFF8, 32'h10, 32'h0, 5'd1, 1'b0);
    cyc("jal_wrap", 32'h3008, 1'b1, 1'b0, 1'b1);
    clear_all();
    cyc("jal_target", 32'h8, 1'b1, 1'b0, 1'b0);

    // Load-use hazard on rs2
    set_exe(1'b1, PC_INC, CSR_IDLE, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1);
    id_valid_i = 1'b1; id_rs1_i = 5'd7; id_rs2_i = 5'd5; id_rs_use_i = 2'b10;
    cyc("load_use", 32'hC, 1'b1, 1'b1, 1'b0);
    clear_all();
    cyc("load_use_done", 32'hC, 1'b1, 1'b0, 1'b0);

    // Load to x0 never stalls
    set_exe(1'b1, PC_INC, CSR_IDLE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1);
    id_valid_i = 1'b1; id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rs_use_i = 2'b11;
    cyc("load_x0", 32'h10, 1'b1, 1'b0, 1'b0);

    // Matching register that ID does not read
    set_exe(1'b1, PC_INC, CSR_IDLE, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1);
    id_rs1_i = 5'd7; id_rs2_i = 5'd3; id_rs_use_i = 2'b10;
    cyc("load_unused_rs", 32'h14, 1'b1, 1'b0, 1'b0);
    clear_all();

    // CSR read-after-write: stall through the done cycle
    set_exe(1'b1, PC_INC, CSR_IDLE, 32'h0, 32'h0, 32'h0, 5'd2, 1'b0);
    exe2ctrl_i.csr_ctrl = CSR_WRITE;
    id_valid_i = 1'b1; id_csr_use_i = 1'b1;
    cyc("csr_detect", 32'h18, 1'b1, 1'b1, 1'b0);
    set_exe(1'b0, PC_INC, CSR_IDLE, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    cyc("csr_wait1", 32'h18, 1'b1, 1'b1, 1'b0);
    cyc("csr_wait2", 32'h18, 1'b1, 1'b1, 1'b0);
    wb_csr_done_i = 1'b1;
    cyc("csr_done", 32'h18, 1'b1, 1'b1, 1'b0);
    wb_csr_done_i = 1'b0;
    cyc("csr_resume", 32'h18, 1'b1, 1'b0, 1'b0);
    clear_all();
    cyc("csr_adv", 32'h1C, 1'b1, 1'b0, 1'b0);

    // Reset during CSR_WAIT with a redirect present
    set_exe(1'b1, PC_INC, CSR_WRITE, 32'h0, 32'h0, 32'h0, 5'd2, 1'b0);
    id_valid_i = 1'b1; id_csr_use_i = 1'b1;
    cyc("csr_detect2", 32'h20, 1'b1, 1'b1, 1'b0);
    set_exe(1'b1, PC_SET, CSR_IDLE, 32'h0, 32'h0, 32'h5000, 5'd0, 1'b0);
    rst_i = 1'b1;
    cyc("rst_in_wait", 32'h20, 1'b1, 1'b0, 1'b0);
    cyc("rst_applied", RST_PC, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    clear_all();
    cyc("rst_release", RST_PC, 1'b0, 1'b0, 1'b0);
    cyc("rst_valid", RST_PC, 1'b1, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
